// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel word layout and swap FSM state type.
package fb_pkg;

    localparam int PANEL_COLS     = 64;
    localparam int PANEL_ROWPAIRS = 16;
    localparam int FB_ADDR_W      = $clog2(PANEL_COLS * PANEL_ROWPAIRS);
    localparam int FB_DATA_W      = 6;

    typedef struct packed {
        logic r1;
        logic g1;
        logic b1;
        logic r2;
        logic g2;
        logic b2;
    } pixel_pair_t;

    typedef enum logic [0:0] {
        RUN       = 1'b0,
        SWAP_WAIT = 1'b1
    } swap_state_e;

endpackage

// File: rtl/fb_swap_ctrl.sv
// Bank swap controller: holds a finished frame until the scanner reaches a safe
// swap point, then flips the displayed bank.
module fb_swap_ctrl
    import fb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_frame_done,
    input  logic i_frame_start,
    output logic o_front_bank,
    output logic o_swap_pend,
    output logic o_overrun
);

    swap_state_e r_state;
    logic        r_front_bank;
    logic        r_swap_pend;
    logic        r_overrun;

    // Swap FSM with registered front_bank / swap_pend / sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RUN;
            r_front_bank <= 1'b0;
            r_swap_pend  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    // A coincident frame_start is ignored: the new frame must wait a full scan
                    if (i_frame_done) begin
                        r_state     <= SWAP_WAIT;
                        r_swap_pend <= 1'b1;
                    end else begin
                        r_state     <= RUN;
                        r_swap_pend <= 1'b0;
                    end
                end
                SWAP_WAIT: begin
                    if (i_frame_done) begin
                        r_overrun <= 1'b1;
                    end
                    if (i_frame_start) begin
                        r_state      <= RUN;
                        r_swap_pend  <= 1'b0;
                        r_front_bank <= ~r_front_bank;
                    end else begin
                        r_state      <= SWAP_WAIT;
                        r_swap_pend  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= RUN;
                    r_swap_pend <= 1'b0;
                end
            endcase
        end
    end

    assign o_front_bank = r_front_bank;
    assign o_swap_pend  = r_swap_pend;
    assign o_overrun    = r_overrun;

endmodule

// File: rtl/fb_arbiter.sv
// Single-port double-buffered framebuffer arbiter: scanner reads the front bank,
// SPI loader writes the back bank, with a starvation bound on the writer.
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W       = FB_ADDR_W,
    parameter int DATA_W       = FB_DATA_W,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rd_gnt,
    output logic              o_rd_valid,
    output logic [DATA_W-1:0] o_rd_data,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    output logic              o_wr_gnt,
    input  logic              i_frame_done,
    input  logic              i_frame_start,
    output logic [ADDR_W:0]   o_ram_addr,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_front_bank,
    output logic              o_swap_pend,
    output logic              o_overrun
);

    localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic             w_front_bank;
    logic             w_swap_pend;
    logic             w_wr_ok;
    logic             w_force_wr;
    logic             w_rd_gnt;
    logic             w_wr_gnt;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             r_rd_valid;

    fb_swap_ctrl u_swap_ctrl (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame_done  (i_frame_done),
        .i_frame_start (i_frame_start),
        .o_front_bank  (w_front_bank),
        .o_swap_pend   (w_swap_pend),
        .o_overrun     (o_overrun)
    );

    // Grant decision: reader has priority unless the writer has hit its starvation bound
    always_comb begin
        w_wr_ok    = 1'b0;
        w_force_wr = 1'b0;
        w_rd_gnt   = 1'b0;
        w_wr_gnt   = 1'b0;
        if (rst_n) begin
            w_wr_ok    = i_wr_req & ~w_swap_pend;
            w_force_wr = w_wr_ok & (r_starve_cnt == CNT_MAX);
            w_rd_gnt   = i_rd_req & ~w_force_wr;
            w_wr_gnt   = w_wr_ok & (~i_rd_req | w_force_wr);
        end else begin
            w_rd_gnt   = 1'b0;
            w_wr_gnt   = 1'b0;
        end
    end

    // RAM port mux: idle cycles leave the address on the read path
    always_comb begin
        o_ram_addr  = {w_front_bank, i_rd_addr};
        o_ram_we    = 1'b0;
        o_ram_wdata = {DATA_W{1'b0}};
        if (w_wr_gnt) begin
            o_ram_addr  = {~w_front_bank, i_wr_addr};
            o_ram_we    = 1'b1;
            o_ram_wdata = i_wr_data;
        end else begin
            o_ram_we    = 1'b0;
        end
    end

    // Count consecutive denied write-request cycles, saturating at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else if (!w_wr_ok || w_wr_gnt) begin
            r_starve_cnt <= {CNT_W{1'b0}};
        end else if (r_starve_cnt < CNT_MAX) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end else begin
            r_starve_cnt <= CNT_MAX;
        end
    end

    // Read data returns one cycle after the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_gnt;
        end
    end

    assign o_rd_gnt     = w_rd_gnt;
    assign o_wr_gnt     = w_wr_gnt;
    assign o_rd_valid   = r_rd_valid;
    assign o_rd_data    = i_ram_rdata;
    assign o_front_bank = w_front_bank;
    assign o_swap_pend  = w_swap_pend;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with an emulated RAM and a per-cycle reference model.
module tb_fb_arbiter;

    localparam int AW  = 10;
    localparam int DW  = 6;
    localparam int LIM = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_gnt;
    logic          frame_done;
    logic          frame_start;
    logic [AW:0]   ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          front_bank;
    logic          swap_pend;
    logic          overrun;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem    [2048];
    logic [DW-1:0] shadow [2048];
    bit            mem_loaded = 1'b0;

    int            m_denied;
    bit            m_front, m_pend, m_ovr, m_vld;
    logic [DW-1:0] m_rdata;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rd_req      (rd_req),
        .i_rd_addr     (rd_addr),
        .o_rd_gnt      (rd_gnt),
        .o_rd_valid    (rd_valid),
        .o_rd_data     (rd_data),
        .i_wr_req      (wr_req),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_wr_gnt      (wr_gnt),
        .i_frame_done  (frame_done),
        .i_frame_start (frame_start),
        .o_ram_addr    (ram_addr),
        .o_ram_we      (ram_we),
        .o_ram_wdata   (ram_wdata),
        .i_ram_rdata   (ram_rdata),
        .o_front_bank  (front_bank),
        .o_swap_pend   (swap_pend),
        .o_overrun     (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int i);
        return DW'((i * 7 + 3) & 63);
    endfunction

    // Emulated synchronous single-port RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 2048; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_denied = 0;
        m_front  = 1'b0;
        m_pend   = 1'b0;
        m_ovr    = 1'b0;
        m_vld    = 1'b0;
        m_rdata  = '0;
    endtask

    // One model cycle: compare outputs against the rules, then advance state
    task automatic model_step();
        bit          wok, starved, rg, wg;
        logic [AW:0] exp_addr;
        if (!rst_n) begin
            chk("rst_rd_gnt", rd_gnt, 0);
            chk("rst_wr_gnt", wr_gnt, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_front", front_bank, 0);
            chk("rst_pend", swap_pend, 0);
            chk("rst_overrun", overrun, 0);
            model_reset();
            return;
        end
        wok     = wr_req && !m_pend;
        starved = wok && (m_denied == LIM);
        rg      = rd_req && !starved;
        wg      = wok && !rg;
        exp_addr = wg ? {~m_front, wr_addr} : {m_front, rd_addr};
        chk("m_rd_gnt", rd_gnt, rg);
        chk("m_wr_gnt", wr_gnt, wg);
        chk("m_ram_we", ram_we, wg);
        chk("m_ram_addr", ram_addr, exp_addr);
        if (wg) chk("m_ram_wdata", ram_wdata, wr_data);
        chk("m_rd_valid", rd_valid, m_vld);
        if (m_vld) chk("m_rd_data", rd_data, m_rdata);
        chk("m_front", front_bank, m_front);
        chk("m_pend", swap_pend, m_pend);
        chk("m_overrun", overrun, m_ovr);

        m_vld   = rg;
        m_rdata = shadow[{m_front, rd_addr}];
        if (wg) shadow[{~m_front, wr_addr}] = wr_data;
        if (wok && !wg) m_denied = (m_denied < LIM) ? m_denied + 1 : LIM;
        else            m_denied = 0;
        if (!m_pend) begin
            if (frame_done) m_pend = 1'b1;
        end else begin
            if (frame_done) m_ovr = 1'b1;
            if (frame_start) begin
                m_front = ~m_front;
                m_pend  = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) shadow[i] = init_word(i);
        model_reset();
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0;
        wr_data = '0; frame_done = 1'b0; frame_start = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Read-only access to front bank 0
        rd_req = 1'b1; rd_addr = 10'h005;
        #1;
        chk("t1_rd_gnt", rd_gnt, 1);
        chk("t1_ram_addr", ram_addr, 11'h005);
        chk("t1_ram_we", ram_we, 0);
        tick();
        rd_req = 1'b0;
        #1;
        chk("t1_rd_valid", rd_valid, 1);
        chk("t1_rd_data", rd_data, 6'h26);

        // Sustained contention: 8 reads then one forced write, repeating
        rd_req = 1'b1; rd_addr = 10'h020; wr_req = 1'b1; wr_addr = 10'h010; wr_data = 6'h11;
        for (int i = 0; i < 18; i++) begin
            #1;
            chk("t2_wr_gnt", wr_gnt, (i == 8) || (i == 17));
            chk("t2_rd_gnt", rd_gnt, !((i == 8) || (i == 17)));
            tick();
        end

        // Uncontended write lands in back bank 1
        rd_req = 1'b0; wr_addr = 10'h3FF; wr_data = 6'h2A;
        #1;
        chk("t3_wr_gnt", wr_gnt, 1);
        chk("t3_ram_addr", ram_addr, 11'h7FF);
        chk("t3_ram_we", ram_we, 1);
        chk("t3_ram_wdata", ram_wdata, 6'h2A);
        tick();
        wr_req = 1'b0;

        // Frame swap: writes blocked while pending, resume into bank 0 after
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0; wr_req = 1'b1; wr_addr = 10'h3FF; wr_data = 6'h15;
        #1;
        chk("t4_pend", swap_pend, 1);
        chk("t4_wr_blocked", wr_gnt, 0);
        chk("t4_we_blocked", ram_we, 0);
        repeat (19) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        #1;
        chk("t4_front", front_bank, 1);
        chk("t4_pend_clr", swap_pend, 0);
        chk("t4_wr_resume", wr_gnt, 1);
        chk("t4_ram_addr", ram_addr, 11'h3FF);
        tick();
        wr_req = 1'b0; rd_req = 1'b1; rd_addr = 10'h3FF;
        tick();
        rd_req = 1'b0;
        #1;
        chk("t4_rd_valid", rd_valid, 1);
        chk("t4_rd_data", rd_data, 6'h2A);

        // Coincident done/start, then overrun
        frame_done = 1'b1; frame_start = 1'b1;
        tick();
        frame_done = 1'b0; frame_start = 1'b0;
        #1;
        chk("t5_pend", swap_pend, 1);
        chk("t5_no_toggle", front_bank, 1);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        #1;
        chk("t5_overrun", overrun, 1);
        chk("t5_pend_hold", swap_pend, 1);
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        #1;
        chk("t5_front", front_bank, 0);
        chk("t5_pend_clr", swap_pend, 0);
        repeat (3) tick();
        chk("t5_overrun_sticky", overrun, 1);

        // Async reset mid-read with swap pending on bank 1
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0; frame_start = 1'b1;
        tick();
        frame_start = 1'b0; frame_done = 1'b1;
        tick();
        frame_done = 1'b0; rd_req = 1'b1; rd_addr = 10'h005;
        tick();
        #1;
        chk("t6_pre_valid", rd_valid, 1);
        chk("t6_pre_front", front_bank, 1);
        chk("t6_pre_pend", swap_pend, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_valid", rd_valid, 0);
        chk("t6_front", front_bank, 0);
        chk("t6_pend", swap_pend, 0);
        chk("t6_overrun", overrun, 0);
        chk("t6_rd_gnt", rd_gnt, 0);
        repeat (2) tick();
        rst_n = 1'b1; rd_req = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
